qed_issue_sched: RTL and testbench
==================================

Name: qed_issue_sched

Overview:
- Instruction-issue controller for the SQED harness, sitting between the fetch unit and the core's decode input.
- In the original phase it issues original instructions (registers x1–x15) and queues their duplicated forms (registers x17–x31).
- On an external commit request it switches to issuing the queued duplicates in order.
- After the queue drains and a pipeline-drain interval elapses, it raises the consistency-check window used by the formal property checker.

Parameters:
- DEPTH, 8, duplicate-queue entries (power of 2, ≥2)
- CNT_W, $clog2(DEPTH)+1, width of the original/duplicate counters
- DRAIN_CYCLES, 5, NOP cycles issued after the last duplicate before the check window opens (1..15)
- NOP, 32'h00000013, instruction issued when nothing valid is available

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_instr  in  32  fetched original instruction
- ifu_valid  in  1  ifu_instr is valid
- ifu_ready  out  1  instruction accepted this cycle (combinational)
- exec_dup  in  1  commit request: switch to the duplicate phase (free input under formal)
- pipe_stall  in  1  core cannot accept an instruction; the block freezes
- qed_instr  out  32  registered instruction to decode
- qed_vld  out  1  qed_instr is valid
- sif_commit  out  1  high from the ORIG->DUP transition until reset
- sif_commit_pulsed  out  1  one-cycle pulse on the ORIG->DUP transition
- qed_num_orig  out  CNT_W  originals accepted
- qed_num_dup  out  CNT_W  duplicates issued
- qed_check_valid  out  1  check window open
- qic_full  out  1  duplicate queue full

Behaviour:
- Reset values: qed_instr=NOP, qed_vld=0, sif_commit=0, sif_commit_pulsed=0, both counters 0, qed_check_valid=0, queue head=tail=0, state ORIG.
- Reset asserted mid-operation aborts any phase; all state returns to the reset values on the next edge.
- Duplicate transform (combinational, applied on enqueue):
  - R-type (opcode 0110011): rd, rs1, rs2 each get bit4 set when the field is nonzero.
  - I-ALU (0010011): rd, rs1 get bit4 set when nonzero.
  - LUI (0110111): rd gets bit4 set when nonzero.
  - Field value 0 stays 0.
  - Any other opcode: both original and duplicate are replaced by NOP.
- ifu_ready = (state==ORIG) && !qic_full && !exec_dup && !pipe_stall.
- pipe_stall=1: no state, counter, queue or output register changes; sif_commit_pulsed is held 0 during the stall.
- State ORIG:
  - Accept (ifu_valid && ifu_ready): qed_instr<=original (NOP-substituted if unsupported), qed_vld<=1, enqueue duplicate at tail, tail+1 mod DEPTH, num_orig+1.
  - No accept: qed_instr<=NOP, qed_vld<=0.
  - exec_dup=1 with a non-empty queue and no stall: -> DUP, sif_commit<=1, pulse high for exactly one cycle; no fetch accepted that cycle.
  - exec_dup=1 with an empty queue: ignored; the state stays ORIG.
  - Queue full: ifu_ready=0, NOP issued, waits for exec_dup.
- State DUP:
  - Each unstalled cycle: qed_instr<=queue[head], qed_vld<=1, head+1 mod DEPTH, num_dup+1.
  - The cycle the last entry issues: -> DRAIN with drain counter=DRAIN_CYCLES.
  - exec_dup and ifu_valid are ignored.
- State DRAIN:
  - NOP issued, qed_vld=0.
  - Counter decrements on unstalled cycles; at 0 -> DONE.
- State DONE (terminal until rst):
  - qed_check_valid=1 (registered, asserted the cycle DONE is entered).
  - NOP issued.
  - qed_num_orig == qed_num_dup holds by construction.
- Full/empty: count-based occupancy. Full when occupancy==DEPTH; empty when it is 0. Pointers wrap mod DEPTH.
- Counters saturate at 2^CNT_W-1; they are unreachable under DEPTH sizing.

Test Plan:
- Reset then ifu_valid with ADD x3,x1,x2 (0x002081B3), exec_dup=0 -> next cycle qed_instr=0x002081B3, qed_vld=1, num_orig=1; the queue holds 0x012889B3.
- Then exec_dup=1 -> sif_commit_pulsed=1 for one cycle, sif_commit stays 1; the next issue is 0x012889B3, num_dup=1; NOPs follow for 5 cycles, then qed_check_valid=1.
- ADDI x1,x0,5 (0x00500093) accepted -> duplicate 0x00500893 (rs1 stays x0); SW instruction accepted -> NOP issued in both phases.
- 8 accepted instructions with exec_dup=0 -> qic_full=1, ifu_ready=0, NOP issued; the 9th is not accepted. exec_dup=1 -> 8 duplicates issued in fetch order, head wraps to 0.
- exec_dup=1 with an empty queue, plus exec_dup and ifu_valid in the same cycle with one entry queued -> the first stays ORIG; in the second the instruction is not accepted and the block enters DUP.
- pipe_stall=1 for 3 cycles mid-DUP -> qed_instr, counters and head frozen; rst=1 in DRAIN -> all outputs return to reset values and state returns to ORIG.

Source files
------------

// File: rtl/qed_issue_sched_if.sv
// Handshake bundle between the fetch side, the issue scheduler and the core.
//   slave  : scheduler view (fetch/commit/stall in, issue and status out)
//   master : environment view (drives fetch/commit/stall, observes issue)
//   ifu_instr/ifu_valid/ifu_ready : fetch handshake
//   exec_dup                      : commit request into the duplicate phase
//   pipe_stall                    : core back-pressure, freezes the scheduler
//   qed_instr/qed_vld             : registered instruction to decode
//   sif_commit/sif_commit_pulsed  : duplicate-phase level and entry pulse
//   qed_num_orig/qed_num_dup      : originals accepted / duplicates issued
//   qed_check_valid/qic_full      : check window open / duplicate queue full
interface qed_issue_sched_if #(
    parameter int CNT_W = 4
);
    logic [31:0]      ifu_instr;
    logic             ifu_valid;
    logic             ifu_ready;
    logic             exec_dup;
    logic             pipe_stall;
    logic [31:0]      qed_instr;
    logic             qed_vld;
    logic             sif_commit;
    logic             sif_commit_pulsed;
    logic [CNT_W-1:0] qed_num_orig;
    logic [CNT_W-1:0] qed_num_dup;
    logic             qed_check_valid;
    logic             qic_full;

    modport master (
        output ifu_instr, ifu_valid, exec_dup, pipe_stall,
        input  ifu_ready, qed_instr, qed_vld, sif_commit, sif_commit_pulsed,
               qed_num_orig, qed_num_dup, qed_check_valid, qic_full
    );

    modport slave (
        input  ifu_instr, ifu_valid, exec_dup, pipe_stall,
        output ifu_ready, qed_instr, qed_vld, sif_commit, sif_commit_pulsed,
               qed_num_orig, qed_num_dup, qed_check_valid, qic_full
    );
endinterface

// File: rtl/qed_issue_sched.sv
// SQED instruction-issue scheduler. Issues original instructions while
// queueing their register-remapped duplicates, replays the duplicates on a
// commit request, waits out a pipeline drain and then opens the check window.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : qed_issue_sched_if.slave (fetch handshake, commit, stall, issue
//          outputs and status flags)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_ORIG  | accept originals, issue them, enqueue their duplicates
// ST_DUP   | issue queued duplicates in fetch order, one per cycle
// ST_DRAIN | issue NOPs for DRAIN_CYCLES cycles so the pipeline empties
// ST_DONE  | check window open, NOPs only, held until reset
module qed_issue_sched #(
    parameter int          DEPTH        = 8,
    parameter int          CNT_W        = $clog2(DEPTH) + 1,
    parameter int          DRAIN_CYCLES = 5,
    parameter logic [31:0] NOP          = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    qed_issue_sched_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [1:0] {ST_ORIG, ST_DUP, ST_DRAIN, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [3:0]         drain_q, drain_d;
    logic [31:0]        instr_q, instr_d;
    logic               vld_q, vld_d;
    logic               commit_q, commit_d;
    logic               pulse_q, pulse_d;
    logic               check_q, check_d;
    logic [CNT_W-1:0]   num_orig_q, num_orig_d;
    logic [CNT_W-1:0]   num_dup_q, num_dup_d;
    logic [31:0]        mem_q [DEPTH];

    logic               q_full, q_empty;
    logic               ready, accept, commit_go;
    logic               supported;
    logic [31:0]        orig_fix, dup_fix, dup_raw;
    logic [6:0]         opcode;

    // Duplicate transform: nonzero register fields move from x1..x15 to
    // x17..x31 by setting bit 4; x0 is left alone so its semantics survive.
    assign opcode    = bus.ifu_instr[6:0];
    assign supported = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LUI);

    always_comb begin
        dup_raw = bus.ifu_instr;
        dup_raw[11] = bus.ifu_instr[11] | (|bus.ifu_instr[11:7]);
        if (opcode == OP_R || opcode == OP_I) begin
            dup_raw[19] = bus.ifu_instr[19] | (|bus.ifu_instr[19:15]);
        end
        if (opcode == OP_R) begin
            dup_raw[24] = bus.ifu_instr[24] | (|bus.ifu_instr[24:20]);
        end
    end

    assign orig_fix = supported ? bus.ifu_instr : NOP;
    assign dup_fix  = supported ? dup_raw : NOP;

    assign q_full    = (occ_q == OCC_W'(DEPTH));
    assign q_empty   = (occ_q == '0);
    assign ready     = (state_q == ST_ORIG) && !q_full && !bus.exec_dup && !bus.pipe_stall;
    assign accept    = bus.ifu_valid && ready;
    assign commit_go = (state_q == ST_ORIG) && bus.exec_dup && !q_empty && !bus.pipe_stall;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ORIG;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            drain_q    <= '0;
            instr_q    <= NOP;
            vld_q      <= 1'b0;
            commit_q   <= 1'b0;
            pulse_q    <= 1'b0;
            check_q    <= 1'b0;
            num_orig_q <= '0;
            num_dup_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            drain_q    <= drain_d;
            instr_q    <= instr_d;
            vld_q      <= vld_d;
            commit_q   <= commit_d;
            pulse_q    <= pulse_d;
            check_q    <= check_d;
            num_orig_q <= num_orig_d;
            num_dup_q  <= num_dup_d;
        end
    end

    // Queue storage needs no reset: only entries between head and tail are read.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem_q[tail_q] <= dup_fix;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (!bus.pipe_stall) begin
            case (state_q)
                ST_ORIG:  if (commit_go) state_d = ST_DUP;
                ST_DUP:   if (occ_q == OCC_W'(1)) state_d = ST_DRAIN;
                ST_DRAIN: if (drain_q == '0) state_d = ST_DONE;
                default:  state_d = ST_DONE;
            endcase
        end
    end

    // Datapath / output next values. A stall holds everything except the
    // commit pulse, which always falls back to 0.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        drain_d    = drain_q;
        instr_d    = instr_q;
        vld_d      = vld_q;
        commit_d   = commit_q;
        pulse_d    = 1'b0;
        check_d    = check_q;
        num_orig_d = num_orig_q;
        num_dup_d  = num_dup_q;
        if (!bus.pipe_stall) begin
            case (state_q)
                ST_ORIG: begin
                    instr_d = accept ? orig_fix : NOP;
                    vld_d   = accept;
                    if (accept) begin
                        tail_d     = tail_q + PTR_W'(1);
                        occ_d      = occ_q + OCC_W'(1);
                        num_orig_d = (num_orig_q == '1) ? num_orig_q : num_orig_q + CNT_W'(1);
                    end
                    if (commit_go) begin
                        commit_d = 1'b1;
                        pulse_d  = 1'b1;
                    end
                end
                ST_DUP: begin
                    instr_d   = mem_q[head_q];
                    vld_d     = 1'b1;
                    head_d    = head_q + PTR_W'(1);
                    occ_d     = occ_q - OCC_W'(1);
                    num_dup_d = (num_dup_q == '1) ? num_dup_q : num_dup_q + CNT_W'(1);
                    if (occ_q == OCC_W'(1)) begin
                        drain_d = 4'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    instr_d = NOP;
                    vld_d   = 1'b0;
                    if (drain_q == '0) begin
                        check_d = 1'b1;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
                default: begin
                    instr_d = NOP;
                    vld_d   = 1'b0;
                    check_d = 1'b1;
                end
            endcase
        end
    end

    assign bus.ifu_ready         = ready;
    assign bus.qed_instr         = instr_q;
    assign bus.qed_vld           = vld_q;
    assign bus.sif_commit        = commit_q;
    assign bus.sif_commit_pulsed = pulse_q;
    assign bus.qed_num_orig      = num_orig_q;
    assign bus.qed_num_dup       = num_dup_q;
    assign bus.qed_check_valid   = check_q;
    assign bus.qic_full          = q_full;
endmodule

// File: tb/tb_qed_issue_sched.sv
// Self-checking bench for qed_issue_sched: directed scenarios with literal
// expectations, then randomized episodes checked cycle-by-cycle against a
// queue-based reference model of the issue rules.
module tb_qed_issue_sched;
    localparam int          DEPTH = 8;
    localparam int          CNT_W = 4;
    localparam int          DRAIN = 5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam int P_ORIG = 0, P_DUP = 1, P_DRAIN = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qed_issue_sched_if #(.CNT_W(CNT_W)) bus ();

    qed_issue_sched #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN), .NOP(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // reference model
    int          m_phase;
    logic [31:0] m_q[$];
    logic [31:0] m_instr;
    logic        m_vld, m_commit, m_pulse, m_check;
    int          m_orig, m_dup, m_quiet;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_supported(input logic [31:0] i);
        return (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0010011) || (i[6:0] == 7'b0110111);
    endfunction

    function automatic logic [4:0] remap(input logic [4:0] r);
        return (r == 0 || r >= 16) ? r : r + 5'd16;
    endfunction

    function automatic logic [31:0] model_dup(input logic [31:0] i);
        logic [31:0] o;
        o = i;
        if (!is_supported(i)) return NOP;
        o[11:7] = remap(i[11:7]);
        if (i[6:0] != 7'b0110111) o[19:15] = remap(i[19:15]);
        if (i[6:0] == 7'b0110011) o[24:20] = remap(i[24:20]);
        return o;
    endfunction

    function automatic logic [31:0] model_orig(input logic [31:0] i);
        return is_supported(i) ? i : NOP;
    endfunction

    task automatic model_reset();
        m_phase = P_ORIG;
        m_q.delete();
        m_instr = NOP; m_vld = 0; m_commit = 0; m_pulse = 0; m_check = 0;
        m_orig = 0; m_dup = 0; m_quiet = 0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] ins, input logic ed,
                              input logic st, input logic r);
        if (r) begin
            model_reset();
        end else if (st) begin
            m_pulse = 0;
        end else begin
            m_pulse = 0;
            case (m_phase)
                P_ORIG: begin
                    if (ed && m_q.size() > 0) begin
                        m_phase = P_DUP; m_commit = 1; m_pulse = 1;
                        m_instr = NOP; m_vld = 0;
                    end else if (v && !ed && m_q.size() < DEPTH) begin
                        m_instr = model_orig(ins); m_vld = 1;
                        m_q.push_back(model_dup(ins));
                        m_orig++;
                    end else begin
                        m_instr = NOP; m_vld = 0;
                    end
                end
                P_DUP: begin
                    m_instr = m_q.pop_front(); m_vld = 1; m_dup++;
                    if (m_q.size() == 0) begin
                        m_phase = P_DRAIN; m_quiet = 0;
                    end
                end
                P_DRAIN: begin
                    m_instr = NOP; m_vld = 0;
                    m_quiet++;
                    if (m_quiet > DRAIN) begin
                        m_phase = P_DONE; m_check = 1;
                    end
                end
                default: begin
                    m_instr = NOP; m_vld = 0;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        chk("qed_instr", bus.qed_instr, m_instr);
        chk("qed_vld", 32'(bus.qed_vld), 32'(m_vld));
        chk("sif_commit", 32'(bus.sif_commit), 32'(m_commit));
        chk("sif_commit_pulsed", 32'(bus.sif_commit_pulsed), 32'(m_pulse));
        chk("qed_num_orig", 32'(bus.qed_num_orig), 32'(m_orig));
        chk("qed_num_dup", 32'(bus.qed_num_dup), 32'(m_dup));
        chk("qed_check_valid", 32'(bus.qed_check_valid), 32'(m_check));
        chk("qic_full", 32'(bus.qic_full), 32'(m_q.size() == DEPTH));
    endtask

    // One clock cycle: drive, check the combinational ready, advance the
    // model across the edge, then check registered outputs after the edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic ed,
                       input logic st, input logic r);
        bus.ifu_valid  = v;
        bus.ifu_instr  = ins;
        bus.exec_dup   = ed;
        bus.pipe_stall = st;
        rst            = r;
        #1;
        if (!r) begin
            chk("ifu_ready", 32'(bus.ifu_ready),
                32'(m_phase == P_ORIG && m_q.size() < DEPTH && !ed && !st));
        end
        model_step(v, ins, ed, st, r);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(1'b0, NOP, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, NOP, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, NOP, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0110111;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b0000011;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) w[11:7]  = 5'd0;
        if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
        if ($urandom_range(0, 3) == 0) w[24:20] = 5'd0;
        return w;
    endfunction

    initial begin
        bus.ifu_valid = 0; bus.ifu_instr = NOP; bus.exec_dup = 0; bus.pipe_stall = 0;
        model_reset();
        @(posedge clk);
        #1;

        // reset values and the basic ADD round-trip
        do_reset();
        chk("rst_instr", bus.qed_instr, 32'h0000_0013);
        chk("rst_vld", 32'(bus.qed_vld), 32'd0);
        cyc(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0);
        chk("add_issue", bus.qed_instr, 32'h002081B3);
        chk("add_norig", 32'(bus.qed_num_orig), 32'd1);
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b0);
        chk("pulse_on", 32'(bus.sif_commit_pulsed), 32'd1);
        idle();
        chk("add_dup_issue", bus.qed_instr, 32'h012889B3);
        chk("pulse_off", 32'(bus.sif_commit_pulsed), 32'd0);
        chk("commit_held", 32'(bus.sif_commit), 32'd1);
        chk("ndup_one", 32'(bus.qed_num_dup), 32'd1);
        repeat (DRAIN) idle();
        chk("check_closed", 32'(bus.qed_check_valid), 32'd0);
        idle();
        chk("check_open", 32'(bus.qed_check_valid), 32'd1);

        // ADDI keeps x0 as rs1; store becomes NOP in both phases
        do_reset();
        cyc(1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0020A223, 1'b0, 1'b0, 1'b0);
        chk("sw_orig_nop", bus.qed_instr, 32'h0000_0013);
        chk("sw_orig_vld", 32'(bus.qed_vld), 32'd1);
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b0);
        idle();
        chk("addi_dup", bus.qed_instr, 32'h00500893);
        idle();
        chk("sw_dup_nop", bus.qed_instr, 32'h0000_0013);
        repeat (DRAIN + 2) idle();

        // fill the queue, refuse the ninth, replay all eight in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, rnd_instr(), 1'b0, 1'b0, 1'b0);
        chk("full_flag", 32'(bus.qic_full), 32'd1);
        cyc(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0);
        chk("full_refuse_norig", 32'(bus.qed_num_orig), 32'd8);
        chk("full_refuse_vld", 32'(bus.qed_vld), 32'd0);
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b0);
        repeat (DEPTH) idle();
        chk("full_ndup", 32'(bus.qed_num_dup), 32'd8);
        repeat (DRAIN + 2) idle();

        // commit on empty queue ignored; commit with valid fetch same cycle
        do_reset();
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b0);
        chk("empty_commit_ignored", 32'(bus.sif_commit), 32'd0);
        cyc(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0);
        chk("commit_with_fetch", 32'(bus.sif_commit), 32'd1);
        chk("fetch_not_taken", 32'(bus.qed_num_orig), 32'd1);
        repeat (3) idle();

        // stall mid-DUP, then reset inside DRAIN
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, rnd_instr(), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, NOP, 1'b1, 1'b0, 1'b0);
        idle();
        repeat (3) cyc(1'b1, rnd_instr(), 1'b1, 1'b1, 1'b0);
        chk("stall_ndup", 32'(bus.qed_num_dup), 32'd1);
        chk("stall_pulse", 32'(bus.sif_commit_pulsed), 32'd0);
        repeat (5) idle();
        cyc(1'b0, NOP, 1'b0, 1'b0, 1'b1);
        chk("drain_rst_commit", 32'(bus.sif_commit), 32'd0);
        chk("drain_rst_ndup", 32'(bus.qed_num_dup), 32'd0);
        chk("drain_rst_instr", bus.qed_instr, 32'h0000_0013);

        // randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int c = 0; c < 50; c++) begin
                cyc($urandom_range(0, 99) < 70, rnd_instr(),
                    $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
